upsp_line_buffer: RTL and testbench
===================================

Name: upsp_line_buffer

Overview:
- Sits directly downstream of access_control, on its upsampler-side read port.
- Consumes the raster-order source pixel stream on the ac_upsp_rvalid / ac_upsp_rdata / upsp_ac_rready handshake.
- Keeps one previous image row and emits, for every accepted pixel, a registered 2x2 neighbourhood window to the upsampling core.
- Top-row and left-column edges use replication.

Parameters:
- PIXEL_WIDTH, 24, bits per RGB pixel; equals UPSP_RDDATA_WIDTH.
- CHANNEL_WIDTH, 8, bits per colour channel; PIXEL_WIDTH = 3*CHANNEL_WIDTH.
- SRC_IMG_WIDTH, 960, pixels per source row; line memory depth.
- SRC_IMG_HEIGHT, 540, rows per source frame.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ac_upsp_rvalid  in  1  source pixel valid, from access_control.
- ac_upsp_rdata  in  PIXEL_WIDTH  source pixel, {R,G,B}, R in the MSBs.
- upsp_ac_rready  out  1  this block can accept a pixel.
- win_valid  out  1  window registers hold a valid window.
- win_ready  in  1  upsampling core accepts the window.
- win_p00  out  PIXEL_WIDTH  pixel at (r-1,c-1), above-left.
- win_p01  out  PIXEL_WIDTH  pixel at (r-1,c), above.
- win_p10  out  PIXEL_WIDTH  pixel at (r,c-1), left.
- win_p11  out  PIXEL_WIDTH  pixel at (r,c), current.
- win_row  out  $clog2(SRC_IMG_HEIGHT)  row index r of the window.
- win_col  out  $clog2(SRC_IMG_WIDTH)  column index c of the window.
- win_last  out  1  window belongs to the last pixel of the frame.
- frame_done  out  1  one-cycle pulse after the last window handshake.
- stall_cnt  out  32  output-stall statistic; see Optional Feature.

Behaviour:
- Reset state: win_valid=0, win_p*=0, win_row=0, win_col=0, win_last=0, frame_done=0, stall_cnt=0; internal row/col counters=0.
- After reset, upsp_ac_rready=1.
- Line memory contents are don't-care after reset; they are never read before being written (see row 0 rule).
- Accept condition: acc = ac_upsp_rvalid && upsp_ac_rready.
- Ready rule: upsp_ac_rready = !win_valid || win_ready. This is a single pipeline stage and sustains full throughput of 1 pixel per cycle.
- Latency: a pixel accepted in cycle N appears on the win_* outputs with win_valid=1 in cycle N+1.
- win_* outputs stay stable while win_valid && !win_ready.
- win_valid clears when the window is taken and no new pixel is accepted in the same cycle.
- Storage:
  - line memory row_mem[SRC_IMG_WIDTH] holds row r-1, asynchronous read.
  - left_q holds pixel (r,c-1).
  - upleft_q holds row_mem[c-1] as read at the previous accept.
- On acc at (r,c): read row_mem[c] (old data) first, then write ac_upsp_rdata to row_mem[c] in the same cycle. Read-before-write is mandatory.
- Edge rules:
  - c==0: p10=p11 and p00=p01.
  - r==0: p01=p11 and p00=p10.
  - (0,0): all four window pixels equal the current pixel.
- Counters advance only on acc.
  - col wraps from SRC_IMG_WIDTH-1 to 0, incrementing row.
  - At (SRC_IMG_HEIGHT-1, SRC_IMG_WIDTH-1): win_last is set for that window; row and col both wrap to 0, ready for the next frame with no idle cycle.
- frame_done=1 in the cycle after win_valid && win_ready && win_last; otherwise 0.
- Back-to-back frames: the first pixel of frame k+1 may be accepted in the same cycle the last window of frame k is taken.
- Reset mid-frame: counters return to 0; any pending window is dropped with no frame_done; the next accepted pixel is (0,0).
- Back-pressure: while win_valid && !win_ready, upsp_ac_rready=0 and no state changes.
- No arithmetic beyond counters. Counter widths as in the win_row / win_col ports. No overflow, because counters wrap at their parameter bounds.

Optional Feature:
- Macro: UPSP_LB_STATS_EN.
- Defined: stall_cnt increments each cycle with win_valid && !win_ready. It saturates at 32'hFFFF_FFFF, clears on rst and on frame_done.
- Undefined: stall_cnt is tied to 0 and no counter logic is synthesised. The port list is identical in both builds.

Decomposition:
- Package upsp_pkg provides:
  - CHANNEL_WIDTH.
  - typedef pixel_t: packed struct {r,g,b}, each CHANNEL_WIDTH bits.
  - typedef win_t: packed struct {p00,p01,p10,p11}.
- One sub-module, upsp_line_mem: SRC_IMG_WIDTH x PIXEL_WIDTH single-port array with asynchronous read and synchronous write, read-before-write.
- Counters, edge muxes and the output register stay in upsp_line_buffer.

Test Plan (SRC_IMG_WIDTH=4, SRC_IMG_HEIGHT=3, pixel value = 16*r+c replicated in each channel):
- Reset, then 12 pixels with rvalid=1 and win_ready=1 -> 12 windows, one per cycle from cycle 1.
  - Window (0,0): all four = 0x000000.
  - Window (1,2): p00=0x010101, p01=0x020202, p10=0x111111, p11=0x121212.
  - win_last only on (2,3); frame_done one cycle later.
- Edge check: window (2,0) -> p00=p01=0x101010 and p10=p11=0x202020. Window (0,3) -> p01=p11=0x030303 and p00=p10=0x020202.
- Hold win_ready=0 for 5 cycles after window (1,1) -> upsp_ac_rready=0 and win_* stable for those 5 cycles; with UPSP_LB_STATS_EN, stall_cnt=5; no pixel lost or duplicated afterwards.
- Random rvalid and win_ready (50% each) over 3 consecutive frames -> window sequence identical to the golden model; exactly 3 frame_done pulses.
- Assert rst at pixel (1,2) with win_valid=1 -> next cycle win_valid=0; next accepted pixel is reported as (0,0) with all four window pixels equal to it; no frame_done.
- Build without UPSP_LB_STATS_EN and repeat the stall scenario -> stall_cnt stays 0.

Source files
------------

// File: rtl/upsp_pkg.sv
// Shared pixel and window types for the upsampler line buffer.
package upsp_pkg;

    localparam int CHANNEL_WIDTH = 8;

    typedef struct packed {
        logic [CHANNEL_WIDTH-1:0] r;
        logic [CHANNEL_WIDTH-1:0] g;
        logic [CHANNEL_WIDTH-1:0] b;
    } pixel_t;

    typedef struct packed {
        pixel_t p00;
        pixel_t p01;
        pixel_t p10;
        pixel_t p11;
    } win_t;

endpackage

// File: rtl/upsp_line_mem.sv
// One-row line memory: asynchronous read, synchronous write.
// A read and a write to the same address in one cycle return the old data.
module upsp_line_mem #(
    parameter int DEPTH = 960,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);
    import upsp_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/upsp_line_buffer.sv
// Line buffer producing a registered 2x2 window per accepted source pixel,
// with edge replication. Define UPSP_LB_STATS_EN to enable the stall counter.
module upsp_line_buffer #(
    parameter int PIXEL_WIDTH    = 24,
    parameter int CHANNEL_WIDTH  = 8,
    parameter int SRC_IMG_WIDTH  = 960,
    parameter int SRC_IMG_HEIGHT = 540
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ac_upsp_rvalid,
    input  logic [PIXEL_WIDTH-1:0]            ac_upsp_rdata,
    output logic                              upsp_ac_rready,
    output logic                              win_valid,
    input  logic                              win_ready,
    output logic [PIXEL_WIDTH-1:0]            win_p00,
    output logic [PIXEL_WIDTH-1:0]            win_p01,
    output logic [PIXEL_WIDTH-1:0]            win_p10,
    output logic [PIXEL_WIDTH-1:0]            win_p11,
    output logic [$clog2(SRC_IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(SRC_IMG_WIDTH)-1:0]  win_col,
    output logic                              win_last,
    output logic                              frame_done,
    output logic [31:0]                       stall_cnt
);
    import upsp_pkg::*;

    localparam int COL_W  = $clog2(SRC_IMG_WIDTH);
    localparam int ROW_W  = $clog2(SRC_IMG_HEIGHT);
    localparam int NUM_CH = PIXEL_WIDTH / CHANNEL_WIDTH;

    logic [COL_W-1:0]       r_col;
    logic [ROW_W-1:0]       r_row;
    logic [PIXEL_WIDTH-1:0] r_left;
    logic [PIXEL_WIDTH-1:0] r_upleft;

    logic                   r_win_valid;
    logic [PIXEL_WIDTH-1:0] r_p00, r_p01, r_p10, r_p11;
    logic [ROW_W-1:0]       r_win_row;
    logic [COL_W-1:0]       r_win_col;
    logic                   r_win_last;
    logic                   r_frame_done;

    logic                   w_acc;
    logic                   w_ready;
    logic                   w_col_last;
    logic                   w_row_last;
    logic                   w_top;
    logic                   w_lft;
    logic [PIXEL_WIDTH-1:0] w_above;
    logic [PIXEL_WIDTH-1:0] w_p00, w_p01, w_p10, w_p11;

    assign w_ready    = !r_win_valid || win_ready;
    assign w_acc      = ac_upsp_rvalid && w_ready;
    assign w_col_last = (r_col == COL_W'(SRC_IMG_WIDTH - 1));
    assign w_row_last = (r_row == ROW_W'(SRC_IMG_HEIGHT - 1));
    assign w_top      = (r_row == '0);
    assign w_lft      = (r_col == '0);

    // Row 0 never consumes w_above, so stale memory after reset is harmless.
    upsp_line_mem #(
        .DEPTH (SRC_IMG_WIDTH),
        .WIDTH (PIXEL_WIDTH)
    ) u_line_mem (
        .clk     (clk),
        .i_we    (w_acc),
        .i_addr  (r_col),
        .i_wdata (ac_upsp_rdata),
        .o_rdata (w_above)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam int LO = gi * CHANNEL_WIDTH;
            assign w_p11[LO +: CHANNEL_WIDTH] = ac_upsp_rdata[LO +: CHANNEL_WIDTH];
            assign w_p10[LO +: CHANNEL_WIDTH] = w_lft ? ac_upsp_rdata[LO +: CHANNEL_WIDTH]
                                                      : r_left[LO +: CHANNEL_WIDTH];
            assign w_p01[LO +: CHANNEL_WIDTH] = w_top ? ac_upsp_rdata[LO +: CHANNEL_WIDTH]
                                                      : w_above[LO +: CHANNEL_WIDTH];
            // Top row copies the left neighbour; left column copies the one above.
            assign w_p00[LO +: CHANNEL_WIDTH] = w_top ? w_p10[LO +: CHANNEL_WIDTH] :
                                                w_lft ? w_p01[LO +: CHANNEL_WIDTH] :
                                                        r_upleft[LO +: CHANNEL_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_left       <= '0;
            r_upleft     <= '0;
            r_win_valid  <= 1'b0;
            r_p00        <= '0;
            r_p01        <= '0;
            r_p10        <= '0;
            r_p11        <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_win_last   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= r_win_valid && win_ready && r_win_last;
            if (w_acc) begin
                r_win_valid <= 1'b1;
                r_p00       <= w_p00;
                r_p01       <= w_p01;
                r_p10       <= w_p10;
                r_p11       <= w_p11;
                r_win_row   <= r_row;
                r_win_col   <= r_col;
                r_win_last  <= w_col_last && w_row_last;
                r_left      <= ac_upsp_rdata;
                r_upleft    <= w_above;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end else if (win_ready) begin
                r_win_valid <= 1'b0;
            end
        end
    end

`ifdef UPSP_LB_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || r_frame_done) begin
            r_stall_cnt <= '0;
        end else if (r_win_valid && !win_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

    assign upsp_ac_rready = w_ready;
    assign win_valid      = r_win_valid;
    assign win_p00        = r_p00;
    assign win_p01        = r_p01;
    assign win_p10        = r_p10;
    assign win_p11        = r_p11;
    assign win_row        = r_win_row;
    assign win_col        = r_win_col;
    assign win_last       = r_win_last;
    assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_upsp_line_buffer.sv
// Directed and randomised checks of upsp_line_buffer on a 4x3 frame.
module tb_upsp_line_buffer;
    import upsp_pkg::*;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;
`ifdef UPSP_LB_STATS_EN
    localparam logic [31:0] STALL_EXP = 32'd5;
`else
    localparam logic [31:0] STALL_EXP = 32'd0;
`endif

    logic        clk;
    logic        rst;
    logic        ac_upsp_rvalid;
    logic [23:0] ac_upsp_rdata;
    logic        upsp_ac_rready;
    logic        win_valid;
    logic        win_ready;
    logic [23:0] win_p00, win_p01, win_p10, win_p11;
    logic [1:0]  win_row;
    logic [1:0]  win_col;
    logic        win_last;
    logic        frame_done;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    upsp_line_buffer #(
        .PIXEL_WIDTH    (24),
        .CHANNEL_WIDTH  (8),
        .SRC_IMG_WIDTH  (W),
        .SRC_IMG_HEIGHT (H)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ac_upsp_rvalid (ac_upsp_rvalid),
        .ac_upsp_rdata  (ac_upsp_rdata),
        .upsp_ac_rready (upsp_ac_rready),
        .win_valid      (win_valid),
        .win_ready      (win_ready),
        .win_p00        (win_p00),
        .win_p01        (win_p01),
        .win_p10        (win_p10),
        .win_p11        (win_p11),
        .win_row        (win_row),
        .win_col        (win_col),
        .win_last       (win_last),
        .frame_done     (frame_done),
        .stall_cnt      (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pixel_t pixv(int f, int r, int c);
        pixel_t p;
        logic [7:0] v;
        v   = 8'(64 * f + 16 * r + c);
        p.r = v;
        p.g = v;
        p.b = v;
        return p;
    endfunction

    // Replication model: neighbours outside the frame clamp to row/col 0.
    function automatic win_t exp_win(int f, int r, int c);
        win_t w;
        int rm, cm;
        rm    = (r > 0) ? r - 1 : 0;
        cm    = (c > 0) ? c - 1 : 0;
        w.p00 = pixv(f, rm, cm);
        w.p01 = pixv(f, rm, c);
        w.p10 = pixv(f, r, cm);
        w.p11 = pixv(f, r, c);
        return w;
    endfunction

    task automatic do_reset();
        rst            = 1'b1;
        ac_upsp_rvalid = 1'b0;
        ac_upsp_rdata  = '0;
        win_ready      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({win_valid, win_last, win_row, win_col, frame_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 0", {win_valid, win_last, win_row, win_col, frame_done});
        end
        n_checks++;
        if ({win_p00, win_p01, win_p10, win_p11} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_pix got %h exp 0", {win_p00, win_p01, win_p10, win_p11});
        end
        n_checks++;
        if (stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stall got %0d exp 0", stall_cnt);
        end
        n_checks++;
        if (upsp_ac_rready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rready got %b exp 1", upsp_ac_rready);
        end
        $display("test_reset done");
    endtask

    // Streams one full frame at full rate; optionally stalls the output for 5 cycles.
    task automatic stream_frame(input string name, input int stall_at);
        int r, c;
        logic [95:0] hand;
        ac_upsp_rvalid = 1'b1;
        ac_upsp_rdata  = pixv(0, 0, 0);
        win_ready      = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(posedge clk);
            #1;
            r = i / W;
            c = i % W;
            n_checks++;
            if ({win_valid, win_last, win_row, win_col} !== {1'b1, (i == N - 1), 2'(r), 2'(c)}) begin
                n_fail++;
                $display("FAIL %s_meta idx=%0d got v=%b l=%b r=%0d c=%0d exp r=%0d c=%0d",
                         name, i, win_valid, win_last, win_row, win_col, r, c);
            end
            n_checks++;
            if ({win_p00, win_p01, win_p10, win_p11} !== exp_win(0, r, c)) begin
                n_fail++;
                $display("FAIL %s_win idx=%0d got %h exp %h", name, i,
                         {win_p00, win_p01, win_p10, win_p11}, exp_win(0, r, c));
            end
            n_checks++;
            if (frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_fd_early idx=%0d got %b exp 0", name, i, frame_done);
            end
            hand = 'x;
            case (i)
                0: hand = {24'h000000, 24'h000000, 24'h000000, 24'h000000};
                3: hand = {24'h020202, 24'h030303, 24'h020202, 24'h030303};
                6: hand = {24'h010101, 24'h020202, 24'h111111, 24'h121212};
                8: hand = {24'h101010, 24'h101010, 24'h202020, 24'h202020};
                default: ;
            endcase
            if (i == 0 || i == 3 || i == 6 || i == 8) begin
                n_checks++;
                if ({win_p00, win_p01, win_p10, win_p11} !== hand) begin
                    n_fail++;
                    $display("FAIL %s_hand idx=%0d got %h exp %h", name, i,
                             {win_p00, win_p01, win_p10, win_p11}, hand);
                end
            end
            $display("%s window (%0d,%0d) %h %h %h %h", name, win_row, win_col,
                     win_p00, win_p01, win_p10, win_p11);
            if (i < N - 1) ac_upsp_rdata = pixv(0, (i + 1) / W, (i + 1) % W);
            else           ac_upsp_rvalid = 1'b0;
            if (i == stall_at) begin
                win_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    #1;
                    n_checks++;
                    if (upsp_ac_rready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s_rready cyc=%0d got %b exp 0", name, j, upsp_ac_rready);
                    end
                    @(posedge clk);
                    #1;
                    n_checks++;
                    if ({win_valid, win_row, win_col, win_p00, win_p01, win_p10, win_p11} !==
                        {1'b1, 2'(r), 2'(c), exp_win(0, r, c)}) begin
                        n_fail++;
                        $display("FAIL %s_hold cyc=%0d got r=%0d c=%0d %h", name, j, win_row, win_col,
                                 {win_p00, win_p01, win_p10, win_p11});
                    end
                end
                n_checks++;
                if (stall_cnt !== STALL_EXP) begin
                    n_fail++;
                    $display("FAIL %s_stall_cnt got %0d exp %0d", name, stall_cnt, STALL_EXP);
                end
                win_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({frame_done, win_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL %s_fd got fd=%b v=%b exp fd=1 v=0", name, frame_done, win_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({frame_done, stall_cnt} !== 33'h0) begin
            n_fail++;
            $display("FAIL %s_fd_after got fd=%b stall=%0d exp 0", name, frame_done, stall_cnt);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        stream_frame("full", -1);
        $display("test_full_frame done");
    endtask

    task automatic test_stall();
        do_reset();
        stream_frame("stall", 5);
        $display("test_stall done");
    endtask

    task automatic test_random_frames();
        int s, k, fd_cnt, cyc;
        int f, idx;
        do_reset();
        s = 0; k = 0; fd_cnt = 0; cyc = 0;
        while (k < 3 * N && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (frame_done === 1'b1) fd_cnt++;
            win_ready      = 1'($urandom_range(0, 1));
            ac_upsp_rvalid = (s < 3 * N) ? 1'($urandom_range(0, 1)) : 1'b0;
            ac_upsp_rdata  = pixv(s / N, (s % N) / W, s % W);
            #1;
            if (win_valid && win_ready) begin
                f   = k / N;
                idx = k % N;
                n_checks++;
                if ({win_last, win_row, win_col, win_p00, win_p01, win_p10, win_p11} !==
                    {(idx == N - 1), 2'(idx / W), 2'(idx % W), exp_win(f, idx / W, idx % W)}) begin
                    n_fail++;
                    $display("FAIL rand_win k=%0d got l=%b r=%0d c=%0d %h exp r=%0d c=%0d %h", k,
                             win_last, win_row, win_col, {win_p00, win_p01, win_p10, win_p11},
                             idx / W, idx % W, exp_win(f, idx / W, idx % W));
                end
                $display("rand window k=%0d (%0d,%0d) p11=%h", k, win_row, win_col, win_p11);
                k++;
            end
            if (ac_upsp_rvalid && upsp_ac_rready) s++;
        end
        ac_upsp_rvalid = 1'b0;
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_cnt++;
        n_checks++;
        if (k !== 3 * N) begin
            n_fail++;
            $display("FAIL rand_count got %0d windows exp %0d (timeout)", k, 3 * N);
        end
        n_checks++;
        if (fd_cnt !== 3) begin
            n_fail++;
            $display("FAIL rand_frame_done got %0d exp 3", fd_cnt);
        end
        $display("test_random_frames done");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        ac_upsp_rvalid = 1'b1;
        ac_upsp_rdata  = pixv(0, 0, 0);
        win_ready      = 1'b1;
        for (int i = 0; i <= 6; i++) begin
            @(posedge clk);
            #1;
            ac_upsp_rdata = pixv(0, (i + 1) / W, (i + 1) % W);
        end
        n_checks++;
        if ({win_valid, win_row, win_col} !== {1'b1, 2'd1, 2'd2}) begin
            n_fail++;
            $display("FAIL mid_pre got v=%b r=%0d c=%0d exp v=1 r=1 c=2", win_valid, win_row, win_col);
        end
        rst            = 1'b1;
        ac_upsp_rvalid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({win_valid, frame_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_rst got v=%b fd=%b exp 0", win_valid, frame_done);
        end
        rst            = 1'b0;
        ac_upsp_rvalid = 1'b1;
        ac_upsp_rdata  = 24'hABCDEF;
        @(posedge clk);
        #1;
        n_checks++;
        if ({win_valid, win_row, win_col, win_p00, win_p01, win_p10, win_p11} !==
            {1'b1, 2'd0, 2'd0, {4{24'hABCDEF}}}) begin
            n_fail++;
            $display("FAIL mid_first got v=%b r=%0d c=%0d %h exp (0,0) all abcdef", win_valid,
                     win_row, win_col, {win_p00, win_p01, win_p10, win_p11});
        end
        ac_upsp_rvalid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({win_valid, frame_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_after got v=%b fd=%b exp 0", win_valid, frame_done);
        end
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_stall();
        test_random_frames();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
